io_mmio_responder: RTL

Memory-mapped I/O responder on the far end of the core's data-memory port. It decodes the core's M-stage address, write data and byte-enables, and returns read data one cycle later on the core's `din` path, aligned with the W stage. It holds a UART transmit holding register, a UART receive FIFO, and cycle and retired-instruction counters. The top level muxes its `dout` against data BRAM using the registered address-region select.

---
 rtl/io_mmio_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/io_mmio_responder.sv
// io_mmio_responder: MMIO block on the core data port.
// UART TX holding reg, RX FIFO, cycle/instret counters.
module io_mmio_responder #(
  parameter int         RX_DEPTH  = 4,
  parameter logic [3:0] IO_REGION = 4'h8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wea,
  input  logic        re,
  input  logic        instr_valid,
  output logic [31:0] dout,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } tx_state_t;

  tx_state_t r_state;
  tx_state_t w_next;
  logic      w_tx_load;

  logic [31:0] r_dout;
  logic [7:0]  r_tx_data;
  logic [31:0] r_cyc;
  logic [31:0] r_ins;

  logic [7:0]    r_mem [RX_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic        w_sel;
  logic        w_store;
  logic        w_load;
  logic [7:0]  w_off;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_clr;
  logic [31:0] w_rdata;
  logic [7:0]  w_head;

  // Upper address/data bits are not decoded by this block.
  logic w_unused;
  assign w_unused = ^{addr[27:8], wdata[31:8]};

  assign w_sel   = (addr[31:28] == IO_REGION);
  assign w_store = w_sel && (wea != 4'b0);
  assign w_load  = w_sel && re && (wea == 4'b0);
  assign w_off   = addr[7:0];

  assign w_full  = (r_count == CW'(RX_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = uart_rx_valid && !w_full;
  assign w_pop   = w_load && (w_off == 8'h04) && !w_empty;
  assign w_clr   = w_store && (w_off == 8'h18);
  assign w_head  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

  assign uart_tx_valid = (r_state == S_SEND);
  assign uart_tx_data  = r_tx_data;
  assign uart_rx_ready = !w_full;
  assign dout          = r_dout;

  // Read mux: pre-update register state for this cycle's load.
  always_comb begin
    w_rdata = '0;
    case (w_off)
      8'h00:   w_rdata = {30'b0, !w_empty, r_state == S_IDLE};
      8'h04:   w_rdata = {24'b0, w_head};
      8'h10:   w_rdata = r_cyc;
      8'h14:   w_rdata = r_ins;
      default: w_rdata = '0;
    endcase
  end

  // TX next-state: accept a store only while idle.
  always_comb begin
    w_next    = r_state;
    w_tx_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_store && (w_off == 8'h08)) begin
          w_next    = S_SEND;
          w_tx_load = 1'b1;
        end
      end
      S_SEND: begin
        if (uart_tx_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // TX state and latched byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tx_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_tx_load) r_tx_data <= wdata[7:0];
    end
  end

  // Registered read data; zero when not a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dout <= '0;
    else        r_dout <= w_load ? w_rdata : '0;
  end

  // Counters; clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= '0;
      r_ins <= '0;
    end else if (w_clr) begin
      r_cyc <= '0;
      r_ins <= '0;
    end else begin
      r_cyc <= r_cyc + 32'd1;
      r_ins <= r_ins + 32'(instr_valid);
    end
  end

  // FIFO storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= uart_rx_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule
